// File: rtl/product_accumulator.sv
// Accumulates a block of COUNT unsigned 8-bit products into an ACC_W-bit sum, with valid/ready on both sides.
// Optional macro SATURATE_EN: clamp the sum at 2^ACC_W-1 on carry-out instead of wrapping.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for start; last result still visible on acc_out
// S_ACCUM | accepting products until COUNT transfers have been taken
// S_DONE  | result presented on acc_out until acc_ready
module product_accumulator #(
  parameter int ACC_W = 11,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             prod_valid,
  input  logic [7:0]       prod_in,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             xfer;
  logic [ACC_W:0]   sum;

  // prod_ready is decoded from state, so a transfer needs only prod_valid in ACCUM
  assign xfer = (state_q == S_ACCUM) && prod_valid;
  assign sum  = {1'b0, acc_q} + (ACC_W + 1)'(prod_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (xfer && (cnt_q == LAST_IDX)) state_d = S_DONE;
      S_DONE:  if (acc_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if ((state_q == S_IDLE) && start) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
      if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef SATURATE_EN
      acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end
  end

  always_comb begin
    prod_ready = (state_q == S_ACCUM);
    acc_valid  = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    acc_out    = acc_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: default instance (ACC_W=11) and a narrow one (ACC_W=9) on shared inputs.
// Expected results for the narrow instance follow SATURATE_EN when it is defined.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, start, prod_valid, acc_ready;
  logic [7:0]  prod_in;

  logic        pr_a, av_a, busy_a, ovf_a;
  logic [10:0] acc_a;
  logic        pr_b, av_b, busy_b, ovf_b;
  logic [8:0]  acc_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(11), .COUNT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(pr_a), .acc_out(acc_a), .acc_valid(av_a), .acc_ready(acc_ready),
    .busy(busy_a), .overflow(ovf_a)
  );

  product_accumulator #(.ACC_W(9), .COUNT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(pr_b), .acc_out(acc_b), .acc_valid(av_b), .acc_ready(acc_ready),
    .busy(busy_b), .overflow(ovf_b)
  );

  typedef struct {
    int v[8];
    bit stall;
    int hold;
    bit ign;
    int e11;
    int o11;
    int e9w;
    int e9s;
    int o9;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Block result is just the sum of the products, then wrapped or clamped to the width.
  function automatic void model(input int v[8], input int w, output int acc, output int ovf);
    int total;
    int lim;
    total = 0;
    for (int i = 0; i < 8; i++) total += v[i];
    lim = 1 << w;
    ovf = (total >= lim) ? 1 : 0;
`ifdef SATURATE_EN
    acc = (ovf != 0) ? lim - 1 : total;
`else
    acc = total % lim;
`endif
  endfunction

  task automatic run_block(input int v[8], input bit stall, input int hold, input bit ign,
                           output int a11, output int o11, output int a9, output int o9);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_acc_a", 32'(acc_a), 0);
    chk("start_acc_b", 32'(acc_b), 0);
    chk("start_ovf_a", 32'(ovf_a), 0);
    chk("start_ovf_b", 32'(ovf_b), 0);
    chk("start_ready", 32'(pr_a), 1);
    chk("start_busy", 32'(busy_a), 1);
    for (int i = 0; i < 8; i++) begin
      if (stall) begin
        prod_valid = 1'b0;
        start = ign;
        step();
        start = 1'b0;
        chk("stall_ready", 32'(pr_a), 1);
        chk("stall_valid", 32'(av_a), 0);
      end
      prod_valid = 1'b1;
      prod_in = 8'(v[i]);
      step();
      if (i < 7) begin
        chk("mid_ready", 32'(pr_a), 1);
        chk("mid_valid", 32'(av_a), 0);
      end else begin
        chk("last_valid_a", 32'(av_a), 1);
        chk("last_valid_b", 32'(av_b), 1);
        chk("last_ready", 32'(pr_a), 0);
        chk("last_busy", 32'(busy_a), 1);
      end
    end
    prod_valid = 1'b0;
    a11 = int'(acc_a);
    o11 = int'(ovf_a);
    a9  = int'(acc_b);
    o9  = int'(ovf_b);
    for (int h = 0; h < hold; h++) begin
      start = ign;
      step();
      start = 1'b0;
      chk("hold_valid", 32'(av_a), 1);
      chk("hold_acc_a", 32'(acc_a), 32'(a11));
      chk("hold_acc_b", 32'(acc_b), 32'(a9));
    end
    acc_ready = 1'b1;
    start = ign;
    step();
    acc_ready = 1'b0;
    start = 1'b0;
    chk("ret_valid", 32'(av_a), 0);
    chk("ret_busy", 32'(busy_a), 0);
    chk("ret_ready", 32'(pr_a), 0);
    chk("ret_keep_acc", 32'(acc_a), 32'(a11));
    if (ign) begin
      step();
      chk("same_cycle_start_ignored", 32'(busy_a), 0);
    end
  endtask

  initial begin
    vec_t tbl[5];
    int a11, o11, a9, o9;
    int e11, eo11, e9, eo9;
    int rv[8];

    tbl[0] = '{v:'{1,2,3,4,5,6,7,8}, stall:0, hold:0, ign:0, e11:36, o11:0, e9w:36, e9s:36, o9:0};
    tbl[1] = '{v:'{1,2,3,4,5,6,7,8}, stall:1, hold:5, ign:1, e11:36, o11:0, e9w:36, e9s:36, o9:0};
    tbl[2] = '{v:'{225,225,225,225,225,225,225,225}, stall:0, hold:0, ign:0,
               e11:1800, o11:0, e9w:264, e9s:511, o9:1};
    tbl[3] = '{v:'{0,0,0,0,0,0,0,0}, stall:1, hold:2, ign:0, e11:0, o11:0, e9w:0, e9s:0, o9:0};
    tbl[4] = '{v:'{100,200,50,0,225,150,90,10}, stall:0, hold:1, ign:1,
               e11:825, o11:0, e9w:313, e9s:511, o9:1};

    rst_n = 1'b0;
    start = 1'b0;
    prod_valid = 1'b0;
    prod_in = 8'd0;
    acc_ready = 1'b0;
    #12;
    chk("rst_acc", 32'(acc_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(pr_a), 0);
    chk("idle_valid", 32'(av_a), 0);
    chk("idle_ovf", 32'(ovf_a), 0);

    for (int t = 0; t < 5; t++) begin
      run_block(tbl[t].v, tbl[t].stall, tbl[t].hold, tbl[t].ign, a11, o11, a9, o9);
      chk($sformatf("tbl%0d_acc11", t), 32'(a11), 32'(tbl[t].e11));
      chk($sformatf("tbl%0d_ovf11", t), 32'(o11), 32'(tbl[t].o11));
`ifdef SATURATE_EN
      chk($sformatf("tbl%0d_acc9", t), 32'(a9), 32'(tbl[t].e9s));
`else
      chk($sformatf("tbl%0d_acc9", t), 32'(a9), 32'(tbl[t].e9w));
`endif
      chk($sformatf("tbl%0d_ovf9", t), 32'(o9), 32'(tbl[t].o9));
    end

    // Reset in the middle of a block, asserted between clock edges.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1;
      prod_in = 8'(200);
      step();
    end
    prod_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_acc_a", 32'(acc_a), 0);
    chk("midrst_acc_b", 32'(acc_b), 0);
    chk("midrst_ready", 32'(pr_a), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_valid", 32'(av_a), 0);
    chk("midrst_ovf_b", 32'(ovf_b), 0);
    #2;
    rst_n = 1'b1;
    step();
    prod_valid = 1'b1;
    prod_in = 8'd5;
    step();
    chk("postrst_ready", 32'(pr_a), 0);
    chk("postrst_acc", 32'(acc_a), 0);
    prod_valid = 1'b0;
    run_block(tbl[0].v, 1'b0, 0, 1'b0, a11, o11, a9, o9);
    chk("postrst_block_acc", 32'(a11), 36);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 8; i++) rv[i] = int'($urandom_range(0, 15)) * int'($urandom_range(0, 15));
      run_block(rv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a11, o11, a9, o9);
      model(rv, 11, e11, eo11);
      model(rv, 9, e9, eo9);
      chk($sformatf("rnd%0d_acc11", r), 32'(a11), 32'(e11));
      chk($sformatf("rnd%0d_ovf11", r), 32'(o11), 32'(eo11));
      chk($sformatf("rnd%0d_acc9", r), 32'(a9), 32'(e9));
      chk($sformatf("rnd%0d_ovf9", r), 32'(o9), 32'(eo9));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
